// File: rtl/kbd_pkg.sv
// Shared constants and key coordinates for the BBC Micro style keyboard matrix.
package kbd_pkg;

  localparam int KBD_ROWS      = 8;
  localparam int KBD_COLS      = 10;
  localparam int KBD_SHIFT_COL = 0;
  localparam int KBD_CTRL_COL  = 1;
  localparam int KBD_LINK_COL0 = 2;

  typedef struct packed {
    logic [2:0] row;
    logic [3:0] col;
  } kbd_key_t;

  // Frequently used keys as (row, column) pairs in the 8x10 matrix
  localparam kbd_key_t KBD_SHIFT  = '{row: 3'd0, col: 4'd0};
  localparam kbd_key_t KBD_CTRL   = '{row: 3'd0, col: 4'd1};
  localparam kbd_key_t KBD_A      = '{row: 3'd4, col: 4'd1};
  localparam kbd_key_t KBD_RETURN = '{row: 3'd4, col: 4'd9};
  localparam kbd_key_t KBD_ESCAPE = '{row: 3'd7, col: 4'd0};

endpackage

// File: rtl/kbd_col_counter.sv
// Keyboard column counter: /2 phase divider plus a 74LS163-style load/count/wrap counter.
module kbd_col_counter
  import kbd_pkg::*;
#(
  parameter int COLS = KBD_COLS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_en,
  input  logic [3:0] load_col,
  output logic [3:0] column
);

  localparam logic [3:0] LAST_COL = 4'(COLS - 1);

  logic       ph;
  logic [3:0] col_cnt;

  // Any value at or past the last column wraps, so a stale out-of-range load recovers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph      <= 1'b0;
      col_cnt <= 4'd0;
    end else begin
      ph <= ~ph;
      if (!scan_en) begin
        col_cnt <= load_col;
      end else if (ph) begin
        col_cnt <= (col_cnt >= LAST_COL) ? 4'd0 : col_cnt + 4'd1;
      end
    end
  end

  assign column = col_cnt;

endmodule

// File: rtl/bbc_keyboard.sv
// BBC Micro keyboard responder: key matrix with option-link row, autoscan CA2 and direct PA7 read.
module bbc_keyboard
  import kbd_pkg::*;
#(
  parameter int COLS = KBD_COLS,
  parameter int ROWS = KBD_ROWS
) (
  input  logic       clk2MHz,
  input  logic       RESET,
  input  logic       nKBEN,
  input  logic [6:0] PA_OUT,
  output logic       PA7,
  output logic       CA2,
  output logic [3:0] COLUMN,
  input  logic [7:0] LINKS,
  input  logic       KEY_WE,
  input  logic [2:0] KEY_ROW,
  input  logic [3:0] KEY_COL,
  input  logic       KEY_DOWN,
  input  logic       KEY_CLR
);

  localparam logic [3:0] COL_LIMIT = 4'(COLS);
  localparam logic [3:0] LINK_COL  = 4'(KBD_LINK_COL0);

  logic [ROWS-1:0][COLS-1:0] keys;
  logic [ROWS-1:0][COLS-1:0] cells;
  logic [3:0]                col_cnt;
  logic [3:0]                pa_col;
  logic [2:0]                pa_row;
  logic                      pa7_next;
  logic                      ca2_next;
  logic                      key_ok;

  kbd_col_counter #(.COLS(COLS)) u_col_counter (
    .clk      (clk2MHz),
    .reset    (RESET),
    .scan_en  (nKBEN),
    .load_col (PA_OUT[3:0]),
    .column   (col_cnt)
  );

  assign COLUMN = col_cnt;
  assign pa_col = PA_OUT[3:0];
  assign pa_row = PA_OUT[6:4];

  // Row 0 beyond CTRL is wired to the option links, never to stored keys.
  always_comb begin
    cells = keys;
    for (int c = KBD_LINK_COL0; c < COLS; c++) begin
      cells[0][c] = LINKS[c - KBD_LINK_COL0];
    end
  end

  always_comb begin
    pa7_next = 1'b0;
    if (!nKBEN && (pa_col < COL_LIMIT)) begin
      pa7_next = cells[pa_row][pa_col];
    end
    ca2_next = 1'b0;
    if (col_cnt < COL_LIMIT) begin
      for (int r = 1; r < ROWS; r++) begin
        ca2_next = ca2_next | cells[r][col_cnt];
      end
    end
  end

  assign key_ok = (KEY_COL < COL_LIMIT) && !((KEY_ROW == 3'd0) && (KEY_COL >= LINK_COL));

  always_ff @(posedge clk2MHz) begin
    if (RESET) begin
      keys <= '0;
      PA7  <= 1'b0;
      CA2  <= 1'b0;
    end else begin
      PA7 <= pa7_next;
      CA2 <= ca2_next;
      if (KEY_CLR) begin
        keys <= '0;
      end else if (KEY_WE && key_ok) begin
        keys[KEY_ROW][KEY_COL] <= KEY_DOWN;
      end
    end
  end

endmodule

// File: tb/tb_bbc_keyboard.sv
// Self-checking bench for bbc_keyboard: cycle model plus directed literal checks.
module tb_bbc_keyboard;
  import kbd_pkg::*;

  logic       clk2MHz;
  logic       RESET;
  logic       nKBEN;
  logic [6:0] PA_OUT;
  logic       PA7;
  logic       CA2;
  logic [3:0] COLUMN;
  logic [7:0] LINKS;
  logic       KEY_WE;
  logic [2:0] KEY_ROW;
  logic [3:0] KEY_COL;
  logic       KEY_DOWN;
  logic       KEY_CLR;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Model state: pressed keys as a plain array, column as an integer
  bit mk [8][10];
  int m_col = 0;
  bit m_ph = 0;
  bit e_pa7 = 0;
  bit e_ca2 = 0;

  bbc_keyboard dut (
    .clk2MHz  (clk2MHz),
    .RESET    (RESET),
    .nKBEN    (nKBEN),
    .PA_OUT   (PA_OUT),
    .PA7      (PA7),
    .CA2      (CA2),
    .COLUMN   (COLUMN),
    .LINKS    (LINKS),
    .KEY_WE   (KEY_WE),
    .KEY_ROW  (KEY_ROW),
    .KEY_COL  (KEY_COL),
    .KEY_DOWN (KEY_DOWN),
    .KEY_CLR  (KEY_CLR)
  );

  initial begin
    clk2MHz = 0;
    forever #5 clk2MHz = ~clk2MHz;
  end

  function automatic bit mcell(int r, int c);
    if (c >= 10) return 1'b0;
    if (r == 0 && c >= 2) return LINKS[c-2];
    return mk[r][c];
  endfunction

  task automatic model_step();
    if (RESET) begin
      foreach (mk[r, c]) mk[r][c] = 1'b0;
      m_col = 0;
      m_ph  = 0;
      e_pa7 = 0;
      e_ca2 = 0;
    end else begin
      e_pa7 = nKBEN ? 1'b0 : mcell(int'(PA_OUT[6:4]), int'(PA_OUT[3:0]));
      e_ca2 = 0;
      for (int r = 1; r < 8; r++) if (mcell(r, m_col)) e_ca2 = 1;
      if (KEY_CLR) begin
        foreach (mk[r, c]) mk[r][c] = 1'b0;
      end else if (KEY_WE && KEY_COL < 10 && !(KEY_ROW == 0 && KEY_COL >= 2)) begin
        mk[KEY_ROW][KEY_COL] = KEY_DOWN;
      end
      if (!nKBEN) m_col = int'(PA_OUT[3:0]);
      else if (m_ph) m_col = (m_col + 1 >= 10) ? 0 : m_col + 1;
      m_ph = !m_ph;
    end
  endtask

  initial forever begin
    @(posedge clk2MHz);
    model_step();
  end

  initial forever begin
    @(negedge clk2MHz);
    if (chk_en) begin
      checks++;
      if (PA7 !== e_pa7) begin
        errors++;
        $display("FAIL model_pa7 t=%0t got=%b exp=%b", $time, PA7, e_pa7);
      end
      checks++;
      if (CA2 !== e_ca2) begin
        errors++;
        $display("FAIL model_ca2 t=%0t got=%b exp=%b", $time, CA2, e_ca2);
      end
      checks++;
      if (COLUMN !== 4'(m_col)) begin
        errors++;
        $display("FAIL model_column t=%0t got=%0d exp=%0d", $time, COLUMN, m_col);
      end
    end
  end

  task automatic lit(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk2MHz);
      #2;
    end
  endtask

  task automatic press(kbd_key_t k, bit down);
    KEY_WE = 1; KEY_ROW = k.row; KEY_COL = k.col; KEY_DOWN = down;
    step();
    KEY_WE = 0;
  endtask

  task automatic do_reset(int n);
    RESET = 1;
    step(n);
    RESET = 0;
  endtask

  int ones;
  int bound;

  initial begin
    RESET = 1; nKBEN = 0; PA_OUT = '0; LINKS = '0;
    KEY_WE = 0; KEY_ROW = '0; KEY_COL = '0; KEY_DOWN = 0; KEY_CLR = 0;
    step();
    chk_en = 1;
    RESET = 0;
    step();

    // Reset with keys pressed and all links set
    press(KBD_A, 1);
    press(KBD_ESCAPE, 1);
    LINKS = 8'hFF; PA_OUT = 7'h41;
    RESET = 1;
    step(3);
    lit("reset_pa7", int'(PA7), 0);
    lit("reset_ca2", int'(CA2), 0);
    lit("reset_column", int'(COLUMN), 0);
    RESET = 0; LINKS = 8'h00;
    ones = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 10; c++) begin
        PA_OUT = {3'(r), 4'(c)};
        step();
        if (PA7) ones++;
      end
    lit("reset_sweep_ones", ones, 0);

    // Autoscan wrap with no keys
    do_reset(1);
    nKBEN = 1;
    for (int i = 0; i < 22; i++) begin
      lit("scan_column", int'(COLUMN), (i / 2) % 10);
      lit("scan_ca2_idle", int'(CA2), 0);
      step();
    end

    // Autoscan detect RETURN: 2 cycles per 20-cycle scan
    press(KBD_RETURN, 1);
    step(5);
    ones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (CA2) ones++;
    end
    lit("return_ca2_count", ones, 4);

    // SHIFT alone never asserts CA2
    KEY_CLR = 1; step(); KEY_CLR = 0;
    press(KBD_SHIFT, 1);
    step(2);
    ones = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (CA2) ones++;
    end
    lit("shift_ca2_count", ones, 0);

    // Direct read
    KEY_CLR = 1; step(); KEY_CLR = 0;
    nKBEN = 0;
    press(KBD_ESCAPE, 1);
    PA_OUT = 7'h70; step();
    lit("direct_esc_pa7", int'(PA7), 1);
    PA_OUT = 7'h60; step();
    lit("direct_row6_pa7", int'(PA7), 0);
    PA_OUT = 7'h0A; step(2);
    lit("direct_col10_pa7", int'(PA7), 0);
    lit("direct_col10_ca2", int'(CA2), 0);

    // Option links
    LINKS = 8'b0000_0101;
    PA_OUT = 7'h02; step();
    lit("link_c2", int'(PA7), 1);
    PA_OUT = 7'h03; step();
    lit("link_c3", int'(PA7), 0);
    PA_OUT = 7'h04; step();
    lit("link_c4", int'(PA7), 1);
    press('{row: 3'd0, col: 4'd3}, 1);
    PA_OUT = 7'h03; step();
    lit("link_c3_after_we", int'(PA7), 0);
    LINKS = 8'h00;

    // Clear beats write in the same cycle
    KEY_CLR = 1; KEY_WE = 1; KEY_ROW = KBD_A.row; KEY_COL = KBD_A.col; KEY_DOWN = 1;
    step();
    KEY_CLR = 0; KEY_WE = 0; PA_OUT = 7'h41;
    step();
    lit("clr_priority", int'(PA7), 0);

    // Same-cycle write/read: old value now, new value next cycle
    KEY_WE = 1; KEY_ROW = KBD_A.row; KEY_COL = KBD_A.col; KEY_DOWN = 1;
    step();
    KEY_WE = 0;
    lit("wr_rd_same_cycle", int'(PA7), 0);
    step();
    lit("wr_rd_next_cycle", int'(PA7), 1);

    // Reset in the middle of a scan
    nKBEN = 1;
    bound = 0;
    while (COLUMN != 4'd6 && bound < 60) begin
      step();
      bound++;
    end
    lit("wait_column6", int'(COLUMN), 6);
    RESET = 1; step();
    lit("midscan_reset_column", int'(COLUMN), 0);
    RESET = 0; step();
    lit("restart_hold0", int'(COLUMN), 0);
    step();
    lit("restart_col1", int'(COLUMN), 1);
    step(10);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bbc_keyboard.md
Name: bbc_keyboard

Overview:
- Keyboard-side responder to the system VIA's keyboard interface, modelled on the BBC Micro keyboard: column counter, 8x10 key matrix and option-link row.
- Slow-bus latch bit 3 (keyboard enable) selects between two modes:
  - Hardware autoscan, which raises CA2 when a key is pressed.
  - Direct addressing by VIA port A, returning key state on PA7.
- A host/bench-side port sets and clears keys, so the bench and future PS/2 front ends can drive the matrix.

Parameters:
- COLS, 10, number of matrix columns (column index width fixed at 4 bits).
- ROWS, 8, number of matrix rows (row index width fixed at 3 bits).

Ports:
- clk2MHz  in  1  system 2 MHz clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- nKBEN  in  1  latch bit 3; 0 = VIA addresses keys directly, 1 = autoscan.
- PA_OUT  in  7  VIA port A outputs; [3:0] column, [6:4] row.
- PA7  out  1  key state at the addressed row/column (1 = pressed).
- CA2  out  1  1 when any key in rows 1..7 of the current column is pressed.
- COLUMN  out  4  current column counter value.
- LINKS  in  8  option links; LINKS[c-2] is row 0, column c, for c = 2..9.
- KEY_WE  in  1  host key update strobe.
- KEY_ROW  in  3  host key row.
- KEY_COL  in  4  host key column.
- KEY_DOWN  in  1  value to write (1 = pressed).
- KEY_CLR  in  1  release all keys.

Behaviour:
- Reset, synchronous while RESET=1:
  - Matrix cleared, col_cnt=0, divider phase ph=0.
  - PA7=0, CA2=0, COLUMN=0.
  - A reset asserted mid-scan aborts the scan; the scan restarts at column 0 one cycle after RESET falls.
- Divider: ph toggles every clk2MHz cycle. Counter events occur only in cycles with ph=1, giving an effective 1 MHz rate.
- Column counter (74LS163 equivalent):
  - nKBEN=0: col_cnt loads PA_OUT[3:0] every cycle, regardless of ph.
  - nKBEN=1 and ph=1: col_cnt increments; COLS-1 wraps to 0.
  - If nKBEN rises while col_cnt >= COLS, the next increment wraps to 0.
  - COLUMN = col_cnt.
- Effective matrix cell (r,c):
  - Row 0, c >= 2: LINKS[c-2] (links are read-only).
  - All other cells: stored key bit.
  - Any c >= COLS reads as 0.
- CA2 (registered, 1-cycle latency from col_cnt): OR of cells (1..7, col_cnt). CA2 is computed in both modes. Row 0 (SHIFT, CTRL, links) never asserts CA2.
- PA7 (registered, 1-cycle latency from PA_OUT): cell(PA_OUT[6:4], PA_OUT[3:0]) when nKBEN=0; forced 0 when nKBEN=1.
- Host port priority: RESET > KEY_CLR > KEY_WE.
  - KEY_WE writes KEY_DOWN to (KEY_ROW, KEY_COL).
  - The write is ignored if KEY_COL >= COLS, or if KEY_ROW=0 and KEY_COL >= 2.
  - KEY_CLR clears every stored key; LINKS are unaffected.
- Write/read in the same cycle: PA7 and CA2 reflect the old cell value in that cycle and the new value one cycle later.
- Multiple keys pressed: CA2 is the OR of the column. PA7 reports exactly the addressed cell; the model has no ghosting.

Decomposition:
- Shared package kbd_pkg holds:
  - constants KBD_ROWS=8, KBD_COLS=10, KBD_SHIFT_COL=0, KBD_CTRL_COL=1, KBD_LINK_COL0=2;
  - localparams for common keys (e.g. KBD_A = row 4, col 1; KBD_RETURN = row 4, col 9; KBD_ESCAPE = row 7, col 0).
- One sub-module, kbd_col_counter: divider, load/increment/wrap logic and COLUMN output.
- The matrix, LINKS mux and outputs stay in bbc_keyboard.

Test Plan:
- Reset: hold RESET 3 cycles with keys and LINKS=8'hFF applied -> PA7=0, CA2=0, COLUMN=0; matrix empty afterwards (all cells read 0 via PA7 sweep with nKBEN=0).
- Autoscan wrap: nKBEN=1, no keys -> COLUMN steps 0,1,...,9,0 with each value held for 2 clk2MHz cycles; CA2 stays 0.
- Autoscan detect: press row 4, col 9 (RETURN), nKBEN=1 -> CA2=1 exactly for the cycles one cycle after COLUMN=9, i.e. 2 cycles per 20-cycle scan. Press SHIFT (row 0, col 0) alone -> CA2 never 1.
- Direct read: nKBEN=0; press row 7, col 0; PA_OUT=7'h70 -> PA7=1 one cycle later. PA_OUT=7'h60 -> PA7=0. PA_OUT=7'h0A (column 10) -> PA7=0, CA2=0.
- Links: LINKS=8'b0000_0101, nKBEN=0 -> PA_OUT=7'h02 gives PA7=1, 7'h03 gives 0, 7'h04 gives 1. KEY_WE to row 0, col 3 with KEY_DOWN=1 -> 7'h03 still reads 0.
- Priority and timing: KEY_CLR and KEY_WE (row 4, col 1, down) in the same cycle -> cell stays 0. Then KEY_WE alone while PA_OUT=7'h41 -> PA7=0 that cycle, 1 the next. Asserting RESET mid-scan at COLUMN=6 -> COLUMN=0 on the next edge.
